// File: rtl/mem_init_pkg.sv
// mem_initiator shared types: FSM states, access sizes, byte-enable and
// load-extension helpers, default rvalid timeout.
package mem_init_pkg;

   localparam int unsigned DEFAULT_RVALID_TIMEOUT = 255;

   typedef enum logic [2:0] {
      IDLE,
      REQ1,
      WAIT1,
      REQ2,
      WAIT2,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_X = 2'd3
   } size_e;

   // Unshifted byte-enable pattern; the illegal size yields no lanes.
   function automatic logic [3:0] be_mask(input logic [1:0] size);
      case (size)
         SIZE_B:  return 4'b0001;
         SIZE_H:  return 4'b0011;
         SIZE_W:  return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] extend(
      input logic [31:0] d,
      input logic [1:0]  size,
      input logic        sgn
   );
      case (size)
         SIZE_B:  return {{24{sgn & d[7]}}, d[7:0]};
         SIZE_H:  return {{16{sgn & d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mem_init_align.sv
// Lane alignment for mem_initiator: byte enables and write data across a
// two-word window, plus read-data merge and sign/zero extension.
// Ports: off/size/sgn/wdata describe the access, lo/hi are the captured
// bus words; be8, wd64 and rdata are purely combinational results.
module mem_init_align (
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic [7:0]  be8,
   output logic [63:0] wd64,
   output logic [31:0] rdata
);
   import mem_init_pkg::*;

   logic [4:0] sh;

   assign sh    = {off, 3'b000};
   assign be8   = {4'b0000, be_mask(size)} << off;
   assign wd64  = {32'h0, wdata} << sh;
   assign rdata = extend(32'({hi, lo} >> sh), size, sgn);

endmodule

// File: rtl/mem_initiator.sv
// Bus master issuing single load/store commands on a req/gnt/rvalid port,
// splitting misaligned accesses when MEM_INIT_SPLIT_EN is defined.
// Ports: cmd_* command in (valid/ready), rsp_* one-shot completion out,
// data_* memory bus. Without MEM_INIT_SPLIT_EN misaligned -> error.
module mem_initiator
   import mem_init_pkg::*;
#(
   parameter int unsigned RVALID_TIMEOUT = DEFAULT_RVALID_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [31:0] cmd_addr_i,
   input  logic        cmd_we_i,
   input  logic [1:0]  cmd_size_i,
   input  logic        cmd_signed_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [31:0] data_addr_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   state_e      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] lo_q;
   logic [31:0] hi_q;
   logic [31:0] cnt;
   logic [1:0]  size_q;
   logic        we_q;
   logic        sgn_q;
   logic        err_q;

   logic [7:0]  be8;
   logic [63:0] wd64;
   logic [31:0] ext;
   logic        mis;
   logic        go1;
   logic        tmo;
   logic        in_req2;
   logic [29:0] wa;

   mem_init_align u_align (
      .off   (addr_q[1:0]),
      .size  (size_q),
      .sgn   (sgn_q),
      .wdata (wdata_q),
      .lo    (lo_q),
      .hi    (hi_q),
      .be8   (be8),
      .wd64  (wd64),
      .rdata (ext)
   );

   assign mis = |be8[7:4];

   // REQ1 only reaches the bus if the access fits, or can be split.
`ifdef MEM_INIT_SPLIT_EN
   assign go1 = 1'b1;
`else
   assign go1 = ~mis;
`endif

   assign tmo = (RVALID_TIMEOUT != 0) &&
                (cnt == RVALID_TIMEOUT - 1);

   assign in_req2 = (state == REQ2);
   assign wa      = addr_q[31:2] + {29'd0, in_req2};

   assign data_req_o   = ((state == REQ1) && go1) || in_req2;
   assign data_we_o    = data_req_o & we_q;
   assign data_addr_o  = data_req_o ? {wa, 2'b00} : 32'h0;
   assign data_be_o    = in_req2    ? be8[7:4] :
                         data_req_o ? be8[3:0] : 4'h0;
   assign data_wdata_o = in_req2    ? wd64[63:32] :
                         data_req_o ? wd64[31:0] : 32'h0;

   assign cmd_ready_o = (state == IDLE) && !rst_i;
   assign rsp_valid_o = (state == RESP);
   assign rsp_err_o   = (state == RESP) && err_q;
   assign rsp_rdata_o = ((state == RESP) && !err_q && !we_q) ?
                        ext : 32'h0;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         cnt     <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (cmd_valid_i) begin
               addr_q  <= cmd_addr_i;
               wdata_q <= cmd_wdata_i;
               size_q  <= cmd_size_i;
               we_q    <= cmd_we_i;
               sgn_q   <= cmd_signed_i;
               lo_q    <= '0;
               hi_q    <= '0;
               err_q   <= (cmd_size_i == SIZE_X);
               state   <= (cmd_size_i == SIZE_X) ? RESP : REQ1;
            end
            REQ1: if (!go1) begin
               err_q <= 1'b1;
               state <= RESP;
            end else if (data_gnt_i) begin
               cnt   <= '0;
               state <= WAIT1;
            end
            WAIT1: if (data_rvalid_i) begin
               lo_q  <= data_rdata_i;
`ifdef MEM_INIT_SPLIT_EN
               state <= mis ? REQ2 : RESP;
`else
               state <= RESP;
`endif
            end else if (tmo) begin
               err_q <= 1'b1;
               state <= RESP;
            end else begin
               cnt <= cnt + 32'd1;
            end
`ifdef MEM_INIT_SPLIT_EN
            REQ2: if (data_gnt_i) begin
               cnt   <= '0;
               state <= WAIT2;
            end
            WAIT2: if (data_rvalid_i) begin
               hi_q  <= data_rdata_i;
               state <= RESP;
            end else if (tmo) begin
               err_q <= 1'b1;
               state <= RESP;
            end else begin
               cnt <= cnt + 32'd1;
            end
`endif
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator: directed commands against a
// zero-wait memory model, bus and response checks run in own processes.
module tb_mem_initiator;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [31:0] cmd_addr_i;
   logic        cmd_we_i;
   logic [1:0]  cmd_size_i;
   logic        cmd_signed_i;
   logic [31:0] cmd_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        data_req_o;
   logic        data_we_o;
   logic [31:0] data_addr_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_t;

   rsp_t        sq[$];
   bus_t        bq[$];
   logic [31:0] mem [logic [31:0]];

   int n_chk    = 0;
   int n_err    = 0;
   int cyc      = 0;
   int rv_delay = 0;
   bit mute     = 1'b0;

   always #5 clk = ~clk;

   mem_initiator #(.RVALID_TIMEOUT(4)) dut (
      .clk           (clk),
      .rst_i         (rst_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_addr_i    (cmd_addr_i),
      .cmd_we_i      (cmd_we_i),
      .cmd_size_i    (cmd_size_i),
      .cmd_signed_i  (cmd_signed_i),
      .cmd_wdata_i   (cmd_wdata_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_err_o     (rsp_err_o),
      .data_req_o    (data_req_o),
      .data_we_o     (data_we_o),
      .data_addr_o   (data_addr_o),
      .data_be_o     (data_be_o),
      .data_wdata_o  (data_wdata_o),
      .data_gnt_i    (data_gnt_i),
      .data_rvalid_i (data_rvalid_i),
      .data_rdata_i  (data_rdata_i)
   );

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Response monitor
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid_o === 1'b1) begin
            n_chk++;
            if (sq.size() == 0) begin
               n_err++;
               $display("FAIL rsp_unexpected: got rdata=%h err=%b cyc=%0d, required none",
                        rsp_rdata_o, rsp_err_o, cyc);
            end else begin
               e = sq.pop_front();
               if (rsp_rdata_o !== e.rdata || rsp_err_o !== e.err ||
                   cyc != e.cyc) begin
                  n_err++;
                  $display("FAIL rsp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                           rsp_rdata_o, rsp_err_o, cyc, e.rdata, e.err, e.cyc);
               end
            end
         end
      end
   end

   // Memory responder and bus-request checker
   initial begin
      bus_t        e;
      logic [31:0] a;
      logic [31:0] w;
      data_gnt_i    = 1'b1;
      data_rvalid_i = 1'b0;
      data_rdata_i  = '0;
      forever begin
         @(negedge clk);
         if (data_req_o === 1'b1 && data_gnt_i) begin
            n_chk++;
            if (bq.size() == 0) begin
               n_err++;
               $display("FAIL bus_unexpected: got addr=%h be=%b we=%b, required no request",
                        data_addr_o, data_be_o, data_we_o);
            end else begin
               e = bq.pop_front();
               if (data_addr_o !== e.addr || data_be_o !== e.be ||
                   data_we_o !== e.we ||
                   (e.we && data_wdata_o !== e.wdata)) begin
                  n_err++;
                  $display("FAIL bus: got addr=%h be=%b we=%b wd=%h, required addr=%h be=%b we=%b wd=%h",
                           data_addr_o, data_be_o, data_we_o, data_wdata_o,
                           e.addr, e.be, e.we, e.wdata);
               end
            end
            a = data_addr_o;
            w = mem.exists(a) ? mem[a] : 32'h0;
            if (data_we_o) begin
               for (int i = 0; i < 4; i++)
                  if (data_be_o[i]) w[8*i +: 8] = data_wdata_o[8*i +: 8];
               mem[a] = w;
            end
            repeat (rv_delay) @(posedge clk);
            @(posedge clk);
            #1;
            if (!mute) begin
               data_rvalid_i = 1'b1;
               data_rdata_i  = w;
            end
            @(posedge clk);
            #1;
            data_rvalid_i = 1'b0;
            data_rdata_i  = '0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, got, exp);
      end
   endtask

   task automatic bexp(input logic [31:0] a, input logic [3:0] be,
                       input logic we, input logic [31:0] wd);
      bus_t b;
      b.addr  = a;
      b.be    = be;
      b.we    = we;
      b.wdata = wd;
      bq.push_back(b);
   endtask

   task automatic issue(input logic [31:0] a, input logic we,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] wd, input bit exp,
                        input logic [31:0] er, input logic ee,
                        input int lat);
      int   budget;
      bit   acc;
      rsp_t r;
      @(posedge clk);
      #1;
      cmd_valid_i  = 1'b1;
      cmd_addr_i   = a;
      cmd_we_i     = we;
      cmd_size_i   = sz;
      cmd_signed_i = sg;
      cmd_wdata_i  = wd;
      budget = 50;
      acc    = 1'b0;
      while (!acc && budget > 0) begin
         @(negedge clk);
         if (cmd_ready_o) begin
            acc = 1'b1;
            if (exp) begin
               r.rdata = er;
               r.err   = ee;
               r.cyc   = cyc + lat;
               sq.push_back(r);
            end
         end else begin
            budget--;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid_i  = 1'b0;
      cmd_addr_i   = '0;
      cmd_we_i     = 1'b0;
      cmd_size_i   = '0;
      cmd_signed_i = 1'b0;
      cmd_wdata_i  = '0;
      if (!acc) begin
         n_chk++;
         n_err++;
         $display("FAIL accept_timeout: got no accept for addr %h, required accept", a);
      end
   endtask

   task automatic wait_idle();
      int b = 60;
      while ((sq.size() != 0 || bq.size() != 0 || !cmd_ready_o) &&
             b > 0) begin
         @(negedge clk);
         b--;
      end
      if (b == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL idle_timeout: got %0d rsp / %0d bus pending, required 0",
                  sq.size(), bq.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i        = 1'b1;
      cmd_valid_i  = 1'b0;
      cmd_addr_i   = '0;
      cmd_we_i     = 1'b0;
      cmd_size_i   = '0;
      cmd_signed_i = 1'b0;
      cmd_wdata_i  = '0;
      mem[32'h0]  = 32'hAABB_CCDD;
      mem[32'h4]  = 32'h1122_3344;
      mem[32'h8]  = 32'h5566_7788;
      mem[32'h10] = 32'h0;
      mem[32'h20] = 32'h1111_1111;

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
      chk("rst_req",   {31'd0, data_req_o},  32'd0);
      chk("rst_rsp",   {31'd0, rsp_valid_o}, 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, cmd_ready_o}, 32'd1);

      // word store
      bexp(32'h10, 4'b1111, 1'b1, 32'hDEAD_BEEF);
      issue(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF,
            1'b1, 32'h0, 1'b0, 3);
      wait_idle();
      chk("store_word_mem", mem[32'h10], 32'hDEAD_BEEF);

      // byte/half loads from 0x80FF_FF7F
      mem[32'h10] = 32'h80FF_FF7F;
      bexp(32'h10, 4'b1000, 1'b0, 32'h0);
      issue(32'h13, 1'b0, 2'd0, 1'b1, 32'h0,
            1'b1, 32'hFFFF_FF80, 1'b0, 3);
      bexp(32'h10, 4'b0100, 1'b0, 32'h0);
      issue(32'h12, 1'b0, 2'd0, 1'b0, 32'h0,
            1'b1, 32'h0000_00FF, 1'b0, 3);
      bexp(32'h10, 4'b0011, 1'b0, 32'h0);
      issue(32'h10, 1'b0, 2'd1, 1'b1, 32'h0,
            1'b1, 32'hFFFF_FF7F, 1'b0, 3);
      bexp(32'h10, 4'b1100, 1'b0, 32'h0);
      issue(32'h12, 1'b0, 2'd1, 1'b0, 32'h0,
            1'b1, 32'h0000_80FF, 1'b0, 3);
      wait_idle();

      // byte store then word readback
      bexp(32'h20, 4'b0010, 1'b1, 32'h0000_AB00);
      issue(32'h21, 1'b1, 2'd0, 1'b0, 32'h0000_00AB,
            1'b1, 32'h0, 1'b0, 3);
      bexp(32'h20, 4'b1111, 1'b0, 32'h0);
      issue(32'h20, 1'b0, 2'd2, 1'b0, 32'h0,
            1'b1, 32'h1111_AB11, 1'b0, 3);
      wait_idle();

      // illegal size
      issue(32'h40, 1'b0, 2'd3, 1'b0, 32'h0,
            1'b1, 32'h0, 1'b1, 1);
      wait_idle();

      // misaligned word and half loads
`ifdef MEM_INIT_SPLIT_EN
      bexp(32'h4, 4'b1100, 1'b0, 32'h0);
      bexp(32'h8, 4'b0011, 1'b0, 32'h0);
      issue(32'h6, 1'b0, 2'd2, 1'b0, 32'h0,
            1'b1, 32'h7788_1122, 1'b0, 5);
      wait_idle();
      bexp(32'h0, 4'b1000, 1'b0, 32'h0);
      bexp(32'h4, 4'b0001, 1'b0, 32'h0);
      issue(32'h3, 1'b0, 2'd1, 1'b0, 32'h0,
            1'b1, 32'h0000_44AA, 1'b0, 5);
      wait_idle();
`else
      issue(32'h6, 1'b0, 2'd2, 1'b0, 32'h0,
            1'b1, 32'h0, 1'b1, 2);
      wait_idle();
      issue(32'h3, 1'b0, 2'd1, 1'b0, 32'h0,
            1'b1, 32'h0, 1'b1, 2);
      wait_idle();
`endif

      // two extra rvalid wait cycles
      rv_delay = 2;
      bexp(32'h10, 4'b1111, 1'b0, 32'h0);
      issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0,
            1'b1, 32'h80FF_FF7F, 1'b0, 5);
      wait_idle();
      rv_delay = 0;

      // rvalid never comes: error after four waiting cycles
      mute = 1'b1;
      bexp(32'h20, 4'b1111, 1'b0, 32'h0);
      issue(32'h20, 1'b0, 2'd2, 1'b0, 32'h0,
            1'b1, 32'h0, 1'b1, 6);
      wait_idle();
      mute = 1'b0;

      // back-to-back commands
      bexp(32'h10, 4'b1111, 1'b0, 32'h0);
      bexp(32'h20, 4'b1111, 1'b0, 32'h0);
      issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0,
            1'b1, 32'h80FF_FF7F, 1'b0, 3);
      issue(32'h20, 1'b0, 2'd2, 1'b0, 32'h0,
            1'b1, 32'h1111_AB11, 1'b0, 3);
      wait_idle();

      // reset while waiting for rvalid
      mute = 1'b1;
      bexp(32'h10, 4'b1111, 1'b0, 32'h0);
      issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b0, 0);
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(negedge clk);
      chk("wait_rst_req",   {31'd0, data_req_o},  32'd0);
      chk("wait_rst_rsp",   {31'd0, rsp_valid_o}, 32'd0);
      chk("wait_rst_ready", {31'd0, cmd_ready_o}, 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("wait_rst_ready_after", {31'd0, cmd_ready_o}, 32'd1);
      repeat (5) @(negedge clk);
      mute = 1'b0;
      bexp(32'h10, 4'b1111, 1'b1, 32'h1234_5678);
      issue(32'h10, 1'b1, 2'd2, 1'b0, 32'h1234_5678,
            1'b1, 32'h0, 1'b0, 3);
      wait_idle();
      chk("post_rst_store_mem", mem[32'h10], 32'h1234_5678);

      // misaligned store across the top of the address space
`ifdef MEM_INIT_SPLIT_EN
      bexp(32'hFFFF_FFFC, 4'b1100, 1'b1, 32'hF00D_0000);
      bexp(32'h0, 4'b0011, 1'b1, 32'h0000_CAFE);
      issue(32'hFFFF_FFFE, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D,
            1'b1, 32'h0, 1'b0, 5);
      wait_idle();
      chk("wrap_mem0", mem[32'h0], 32'hAABB_CAFE);
`else
      issue(32'hFFFF_FFFE, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D,
            1'b1, 32'h0, 1'b1, 2);
      wait_idle();
      chk("wrap_mem0", mem[32'h0], 32'hAABB_CCDD);
`endif

      chk("queues_drained", sq.size() + bq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Bus-master counterpart of the core-side RAM responder: accepts single load/store commands from a testbench sequencer, DMA-style helper or debug port and drives them onto the req/gnt/rvalid data interface. Computes byte enables, splits misaligned accesses into two aligned word transactions, merges and sign/zero-extends read data, and reports completion or error on a one-shot response strobe. Sits between any command source and the data port of the RAM wrapper, in parallel with or instead of the core's LSU.

## Interface
- RVALID_TIMEOUT, default 255: cycles waited for data_rvalid_i after grant before an error response; 0 disables the timeout.
- clk  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
- cmd_addr_i  in  32  byte address.
- cmd_we_i  in  1  1 = store, 0 = load.
- cmd_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- cmd_signed_i  in  1  sign-extend load result.
- cmd_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  single-cycle completion pulse; no backpressure.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  qualifies rsp_valid_o: illegal size, timeout, or misaligned with split disabled.
- data_req_o, data_we_o  out  1  bus request and write enable.
- data_addr_o  out  32  word-aligned bus address (bits [1:0] always 0).
- data_be_o  out  4  byte enables.
- data_wdata_o  out  32  lane-positioned write data.
- data_gnt_i, data_rvalid_i  in  1  grant and response valid.
- data_rdata_i  in  32  read data.

## Operation
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE: cmd_ready_o = 1; on accept, latch command, go REQ1. Size 3 -> RESP with error, no bus access.
- off = addr[1:0]; be8 = {0001,0011,1111}[size] << off (8 bits); wd64 = wdata << 8*off. Misaligned when be8[7:4] != 0.
- REQ1: data_req_o = 1, addr = {addr[31:2],00}, be = be8[3:0], wdata = wd64[31:0]; held stable until data_gnt_i; then WAIT1.
- WAIT1: on data_rvalid_i capture rdata low word; misaligned -> REQ2, else RESP.
- REQ2/WAIT2: same with addr + 4 (32-bit wrap: 0xFFFF_FFFC + 4 = 0), be8[7:4], wd64[63:32]; capture high word.
- RESP: rsp_valid_o = 1 for one cycle; load data = ({hi,lo} >> 8*off) truncated to size, extended per cmd_signed_i; then IDLE.
- Exactly one outstanding transaction; data_req_o never asserted in WAIT states.
- Writes also wait for data_rvalid_i before completing.
- Timeout: counter clears on entering WAIT1/WAIT2, increments each cycle without data_rvalid_i; reaching RVALID_TIMEOUT -> RESP with error, second half skipped. data_rvalid_i outside WAIT states is ignored.
- Reset (any state): state IDLE, all outputs 0 except cmd_ready_o = 0 while rst_i high, 1 afterwards; in-flight transaction abandoned, no response.

## Timing
- Zero-wait responder (gnt same cycle, rvalid next): accept at cycle 0 -> data_req_o in cycle 1 -> rvalid cycle 2 -> rsp_valid_o cycle 3. Misaligned: rsp_valid_o cycle 5.
- Each extra gnt or rvalid wait cycle adds one cycle.
- Next command accepted earliest in the cycle after rsp_valid_o.
- All outputs registered or decoded from registered state; no combinational path cmd_* -> data_*.

## Configuration
- MEM_INIT_SPLIT_EN defined: misaligned accesses split as above.
- Undefined: REQ2/WAIT2 absent; misaligned command -> RESP with rsp_err_o = 1, rsp_rdata_o = 0, no bus request, latency 2 cycles.

## Structure
- Package mem_init_pkg: state enum, size enum (SIZE_B/H/W), be-mask and extend functions, DEFAULT_RVALID_TIMEOUT constant.
- Sub-module mem_init_align: combinational be8/wd64 generation and read merge/extend; instantiated once in mem_initiator.

## Test plan
- Word store 0x0000_0010, data 0xDEADBEEF, zero-wait responder -> one req, be 1111, addr 0x10, rsp_valid_o cycle 3, err 0.
- Signed byte load 0x0000_0013 with RAM word 0x80FF_FF7F there -> be 1000, rsp_rdata_o 0xFFFF_FF80.
- Word load 0x0000_0006 (split on): reqs to 0x4 be 1100 and 0x8 be 0011; RAM 0x1122_3344 / 0x5566_7788 -> rsp_rdata_o 0x7788_1122 at cycle 5.
- Responder never asserts rvalid, RVALID_TIMEOUT = 4 -> rsp_err_o = 1 four cycles after grant, back to IDLE.
- Half load 0x0000_0003 without MEM_INIT_SPLIT_EN -> no data_req_o, error response at cycle 2.
- rst_i pulsed while in WAIT1 -> data_req_o 0, no rsp_valid_o, next command completes normally.
